// File: rtl/ask4_slicer_mer_if.sv
// Bus bundle for ask4_slicer_mer: symbol-rate sample input plus the
// per-symbol slicer results and the block-averaged MER statistics.
interface ask4_slicer_mer_if #(
    parameter int WIDTH = 18
);
    logic                    sym_clk_en;
    logic                    clear;
    logic signed [WIDTH-1:0] y_in;
    logic [1:0]              sym_out;
    logic signed [WIDTH-1:0] err;
    logic                    sym_valid;
    logic [WIDTH-1:0]        ref_level;
    logic [WIDTH-1:0]        err_pwr;
    logic                    mer_valid;
    logic signed [WIDTH-1:0] dc_est;

    modport master (
        output sym_clk_en, clear, y_in,
        input  sym_out, err, sym_valid, ref_level, err_pwr, mer_valid, dc_est
    );

    modport slave (
        input  sym_clk_en, clear, y_in,
        output sym_out, err, sym_valid, ref_level, err_pwr, mer_valid, dc_est
    );
endinterface

// File: rtl/ask4_slicer_mer.sv
// 4-ASK slicer with self-estimated reference level and block-averaged
// error power for MER reporting. Four stages: S0 capture, S1 slice,
// S2 square, S3 accumulate / block end.
// Optional feature: define MER_DC_REMOVE_EN to subtract the block-mean DC
// estimate at capture; without it dc_est is tied to 0.
module ask4_slicer_mer #(
    parameter int WIDTH    = 18,
    parameter int LOG2N    = 10,
    parameter int REF_INIT = 32768
) (
    input  logic             sys_clk,
    input  logic             reset,
    ask4_slicer_mer_if.slave bus
);
    localparam int AW = WIDTH + LOG2N;
    localparam logic signed [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [LOG2N-1:0] CNT_LAST = {LOG2N{1'b1}};
    localparam logic [WIDTH-1:0] REF_RST  = WIDTH'(REF_INIT);

    typedef enum logic {ACQ = 1'b0, TRACK = 1'b1} state_t;

    // Clamp a one-bit-wider signed value into the sample range.
    function automatic logic signed [WIDTH-1:0] sat(input logic signed [WIDTH:0] v);
        if (v[WIDTH] != v[WIDTH-1]) return v[WIDTH] ? SMIN : SMAX;
        return $signed(v[WIDTH-1:0]);
    endfunction

    state_t                  state_q, state_d;
    logic [2:0]              vld_pipe_q;
    logic signed [WIDTH-1:0] y0_q, y1_q, y2_q;
    logic signed [WIDTH-1:0] y0_d;
    logic signed [WIDTH:0]   y0_ext;
    logic [1:0]              sym_q, sym_d;
    logic signed [WIDTH-1:0] err_q, err_d;
    logic [WIDTH-1:0]        sq_q, sq_d;
    logic [AW-1:0]           acc_abs_q, acc_sq_q, sum_abs, sum_sq;
    logic [LOG2N-1:0]        cnt_q;
    logic [WIDTH-1:0]        ref_q, pwr_q, abs_y2;
    logic                    mer_q, mer_d, blk_end;

    logic signed [WIDTH:0]   y1_ext, ref_ext, a_ext, a3_ext, lvl, err_full;
    logic [WIDTH:0]          a3_raw;
    logic signed [2*WIDTH-1:0] prod;

`ifdef MER_DC_REMOVE_EN
    logic signed [WIDTH-1:0] dc_q;
    logic signed [AW-1:0]    acc_y_q, sum_y;
`endif

    // S0: remove the DC estimate (if built in) and saturate the sample.
    always_comb begin
`ifdef MER_DC_REMOVE_EN
        y0_ext = {bus.y_in[WIDTH-1], bus.y_in} - {dc_q[WIDTH-1], dc_q};
`else
        y0_ext = {bus.y_in[WIDTH-1], bus.y_in};
`endif
        y0_d = sat(y0_ext);
    end

    // S1: slice against ref (=2a); 3a clips so the level stays representable.
    always_comb begin
        sym_d   = 2'b00;
        y1_ext  = {y0_q[WIDTH-1], y0_q};
        ref_ext = {1'b0, ref_q};
        a_ext   = {2'b00, ref_q[WIDTH-1:1]};
        a3_raw  = {1'b0, ref_q} + {2'b00, ref_q[WIDTH-1:1]};
        a3_ext  = (a3_raw > {1'b0, SMAX}) ? $signed({1'b0, SMAX}) : $signed(a3_raw);
        lvl     = -a3_ext;
        if (y1_ext >= ref_ext) begin
            sym_d = 2'b11;
            lvl   = a3_ext;
        end else if (!y1_ext[WIDTH]) begin
            sym_d = 2'b10;
            lvl   = a_ext;
        end else if (y1_ext >= -ref_ext) begin
            sym_d = 2'b01;
            lvl   = -a_ext;
        end
        err_full = y1_ext - lvl;
        err_d    = sat(err_full);
    end

    // S2/S3 combinational: squared error in 1s17 and the running block sums.
    always_comb begin
        prod    = err_q * err_q;
        sq_d    = WIDTH'(prod >> (WIDTH-1));
        abs_y2  = y2_q[WIDTH-1] ? (~y2_q + 1'b1) : y2_q;
        sum_abs = acc_abs_q + AW'(abs_y2);
        sum_sq  = acc_sq_q + AW'(sq_q);
        blk_end = vld_pipe_q[2] && (cnt_q == CNT_LAST);
`ifdef MER_DC_REMOVE_EN
        sum_y   = acc_y_q + AW'(y2_q);
`endif
    end

    // FSM next state; MER is only reported once a reference block exists.
    always_comb begin
        state_d = state_q;
        mer_d   = 1'b0;
        if (bus.clear) begin
            state_d = ACQ;
        end else if (blk_end) begin
            state_d = TRACK;
            mer_d   = (state_q == TRACK);
        end
    end

    // FSM state register.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) state_q <= ACQ;
        else        state_q <= state_d;
    end

    // Valid tags; clear drops everything in flight, coincident strobe included.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset)         vld_pipe_q <= '0;
        else if (bus.clear) vld_pipe_q <= '0;
        else                vld_pipe_q <= {vld_pipe_q[1:0], bus.sym_clk_en};
    end

    // Datapath registers for S0 capture, S1 decision and S2 square.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            y0_q  <= '0;
            y1_q  <= '0;
            y2_q  <= '0;
            sym_q <= '0;
            err_q <= '0;
            sq_q  <= '0;
        end else begin
            if (bus.sym_clk_en && !bus.clear) y0_q <= y0_d;
            if (vld_pipe_q[0] && !bus.clear) begin
                sym_q <= sym_d;
                err_q <= err_d;
                y1_q  <= y0_q;
            end
            if (vld_pipe_q[1] && !bus.clear) begin
                sq_q <= sq_d;
                y2_q <= y1_q;
            end
        end
    end

    // S3 accumulators and symbol counter; reload to zero at block end.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            acc_abs_q <= '0;
            acc_sq_q  <= '0;
            cnt_q     <= '0;
        end else if (bus.clear) begin
            acc_abs_q <= '0;
            acc_sq_q  <= '0;
            cnt_q     <= '0;
        end else if (vld_pipe_q[2]) begin
            cnt_q     <= cnt_q + 1'b1;
            acc_abs_q <= blk_end ? '0 : sum_abs;
            acc_sq_q  <= blk_end ? '0 : sum_sq;
        end
    end

    // Block results: reference level every block, error power only in TRACK.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            ref_q <= REF_RST;
            pwr_q <= '0;
            mer_q <= 1'b0;
        end else begin
            mer_q <= mer_d;
            if (bus.clear)    ref_q <= REF_RST;
            else if (blk_end) ref_q <= sum_abs[AW-1:LOG2N];
            if (mer_d)        pwr_q <= sum_sq[AW-1:LOG2N];
        end
    end

`ifdef MER_DC_REMOVE_EN
    // DC estimate: signed block mean of the (already corrected) samples.
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            acc_y_q <= '0;
            dc_q    <= '0;
        end else if (bus.clear) begin
            acc_y_q <= '0;
            dc_q    <= '0;
        end else if (vld_pipe_q[2]) begin
            acc_y_q <= blk_end ? '0 : sum_y;
            if (blk_end) dc_q <= sum_y[AW-1:LOG2N];
        end
    end
    assign bus.dc_est = dc_q;
`else
    assign bus.dc_est = '0;
`endif

    assign bus.sym_out   = sym_q;
    assign bus.err       = err_q;
    assign bus.sym_valid = vld_pipe_q[1];
    assign bus.ref_level = ref_q;
    assign bus.err_pwr   = pwr_q;
    assign bus.mer_valid = mer_q;
endmodule

// File: tb/tb_ask4_slicer_mer.sv
// Bench for ask4_slicer_mer with N=16 blocks. A block-level reference model
// predicts each decision/error and each block's statistics; a monitor pops
// the predictions as sym_valid / mer_valid pulses arrive.
module tb_ask4_slicer_mer;
    localparam int W  = 18;
    localparam int L  = 4;
    localparam int N  = 1 << L;
    localparam int RI = 32768;
`ifdef MER_DC_REMOVE_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    logic sys_clk = 1'b0;
    logic reset   = 1'b0;

    ask4_slicer_mer_if #(.WIDTH(W)) bus ();

    ask4_slicer_mer #(.WIDTH(W), .LOG2N(L), .REF_INIT(RI)) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus.slave)
    );

    always #5 sys_clk = ~sys_clk;

    int     n_run = 0, n_fail = 0;
    int     exp_sym_q[$], exp_err_q[$], exp_pwr_q[$];
    int     m_ref = RI, m_pwr = 0, m_dc = 0, m_cnt = 0;
    bit     m_track = 1'b0;
    longint m_sa = 0, m_ss = 0, m_sy = 0;
    int     blk[N];
    int     pat[4] = '{-49152, -16384, 16384, 49152};

    task automatic chk(input string tag, input logic signed [63:0] obs, input longint expv);
        n_run++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    function automatic int sat18(input longint v);
        if (v > 131071)  return 131071;
        if (v < -131072) return -131072;
        return int'(v);
    endfunction

    // Reference: slice one sample, book it into the block; close the block after N.
    task automatic model_sym(input int yin, input bit no_end);
        int y, a, t, lvl, s, e;
        y = sat18(longint'(yin) - m_dc);
        a = m_ref / 2;
        t = m_ref + a;
        if (t > 131071) t = 131071;
        if (y >= m_ref)       begin s = 3; lvl = t;  end
        else if (y >= 0)      begin s = 2; lvl = a;  end
        else if (y >= -m_ref) begin s = 1; lvl = -a; end
        else                  begin s = 0; lvl = -t; end
        e = sat18(longint'(y) - lvl);
        exp_sym_q.push_back(s);
        exp_err_q.push_back(e);
        m_sa += (y < 0) ? -y : y;
        m_ss += (longint'(e) * e) >>> 17;
        m_sy += y;
        m_cnt++;
        if (m_cnt == N && !no_end) begin
            if (m_track) begin
                m_pwr = int'(m_ss >>> L);
                exp_pwr_q.push_back(m_pwr);
            end
            m_track = 1'b1;
            m_ref   = int'(m_sa >>> L);
            if (DC_EN) m_dc = int'(m_sy >>> L);
            m_sa = 0; m_ss = 0; m_sy = 0; m_cnt = 0;
        end
    endtask

    task automatic model_clear();
        m_sa = 0; m_ss = 0; m_sy = 0; m_cnt = 0;
        m_ref = RI; m_dc = 0; m_track = 1'b0;
    endtask

    task automatic send(input int n);
        for (int i = 0; i < n; i++) begin
            model_sym(blk[i], 1'b0);
            bus.sym_clk_en = 1'b1;
            bus.y_in       = W'(blk[i]);
            tick();
        end
        bus.sym_clk_en = 1'b0;
    endtask

    task automatic settle(input string tag);
        repeat (6) tick();
        chk({tag, "_sym_drain"}, exp_sym_q.size(), 0);
        chk({tag, "_mer_drain"}, exp_pwr_q.size(), 0);
        chk({tag, "_ref_level"}, bus.ref_level, m_ref);
        chk({tag, "_err_pwr"},   bus.err_pwr, m_pwr);
        chk({tag, "_dc_est"},    $signed(bus.dc_est), m_dc);
        exp_sym_q.delete(); exp_err_q.delete(); exp_pwr_q.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_sym_out"},   bus.sym_out, 0);
        chk({tag, "_err"},       $signed(bus.err), 0);
        chk({tag, "_sym_valid"}, bus.sym_valid, 0);
        chk({tag, "_ref_level"}, bus.ref_level, RI);
        chk({tag, "_err_pwr"},   bus.err_pwr, 0);
        chk({tag, "_mer_valid"}, bus.mer_valid, 0);
        chk({tag, "_dc_est"},    $signed(bus.dc_est), 0);
    endtask

    function automatic int rnd_level();
        return pat[$urandom_range(0, 3)] + int'($urandom_range(0, 6000)) - 3000;
    endfunction

    // Monitor: every result pulse must match the next prediction.
    always @(negedge sys_clk) begin
        if (reset) begin
            if (bus.sym_valid) begin
                chk("sym_pulse_expected", (exp_sym_q.size() > 0) ? 1 : 0, 1);
                if (exp_sym_q.size() > 0) begin
                    chk("sym_out", bus.sym_out, exp_sym_q.pop_front());
                    chk("err", $signed(bus.err), exp_err_q.pop_front());
                end
            end
            if (bus.mer_valid) begin
                chk("mer_pulse_expected", (exp_pwr_q.size() > 0) ? 1 : 0, 1);
                if (exp_pwr_q.size() > 0)
                    chk("mer_err_pwr", bus.err_pwr, exp_pwr_q.pop_front());
            end
        end
    end

    initial begin
        bus.sym_clk_en = 1'b0;
        bus.clear      = 1'b0;
        bus.y_in       = '0;
        reset          = 1'b0;
        repeat (3) tick();
        check_reset_vals("rst_hold");
        reset = 1'b1;
        repeat (4) tick();
        check_reset_vals("rst_idle");

        // Ideal constellation: block 1 acquires, block 2 reports zero power.
        for (int i = 0; i < N; i++) blk[i] = pat[i % 4];
        send(N);
        settle("ideal_b1");
        chk("ideal_b1_ref_const", bus.ref_level, 32768);
        send(N);
        settle("ideal_b2");
        chk("ideal_b2_pwr_const", bus.err_pwr, 0);

        // Noisy constellation, random symbol order.
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < N; i++) blk[i] = rnd_level();
            send(N);
            settle("noisy");
        end

        // Full-range random samples.
        for (int i = 0; i < N; i++) blk[i] = int'($urandom_range(0, 262143)) - 131072;
        send(N);
        settle("fullrange");

        // Saturation: ref at full scale, then small ref with most negative input.
        for (int i = 0; i < N; i++) blk[i] = (i % 2 == 1) ? -131071 : 131071;
        send(N);
        settle("sat_ref_max");
        for (int i = 0; i < N; i++) blk[i] = rnd_level();
        blk[0] = 131071;
        send(N);
        settle("sat_3a");
        for (int i = 0; i < N; i++) blk[i] = (i % 2 == 1) ? -16384 : 16384;
        send(N);
        settle("sat_ref_small");
        for (int i = 0; i < N; i++) blk[i] = rnd_level();
        blk[0] = -131072;
        blk[5] = -131072;
        send(N);
        settle("sat_neg");

        // Clear coinciding with block end and with a strobe.
        for (int i = 0; i < N; i++) blk[i] = rnd_level();
        send(N - 1);
        model_sym(blk[N-1], 1'b1);
        bus.sym_clk_en = 1'b1;
        bus.y_in       = W'(blk[N-1]);
        tick();
        bus.sym_clk_en = 1'b0;
        tick();
        tick();
        bus.clear      = 1'b1;
        bus.sym_clk_en = 1'b1;
        bus.y_in       = W'(12345);
        tick();
        bus.clear      = 1'b0;
        bus.sym_clk_en = 1'b0;
        model_clear();
        chk("clear_mer_valid", bus.mer_valid, 0);
        settle("clear");

        // Thresholds at ref=32768 (fresh after clear, ACQ so no report).
        for (int i = 0; i < N; i++) blk[i] = rnd_level();
        blk[0] = 32768; blk[1] = 0; blk[2] = -32768; blk[3] = -32769;
        send(N);
        settle("thresh");

        // Constant +1024 offset on every symbol, two blocks.
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        model_clear();
        for (int i = 0; i < N; i++) blk[i] = pat[i % 4] + 1024;
        send(N);
        settle("offset_b1");
        send(N);
        settle("offset_b2");

        // Reset in the middle of a block: no partial-block result survives.
        for (int i = 0; i < N; i++) blk[i] = rnd_level();
        send(8);
        repeat (3) tick();
        reset = 1'b0;
        #1;
        check_reset_vals("rst_mid");
        exp_sym_q.delete(); exp_err_q.delete(); exp_pwr_q.delete();
        model_clear();
        m_pwr = 0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        for (int i = 0; i < N; i++) blk[i] = rnd_level();
        send(N);
        settle("post_rst");

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
